// File: rtl/demux_feeder_pkg.sv
// Shared types for the demux feeder: channel geometry, FSM states and FIFO entry layout.
// No logic here; no latency or backpressure of its own.
// Entry width follows ENT_DATA_W, which the top-level DATA_W defaults to.
package demux_feeder_pkg;
    localparam int NUM_CH     = 4;
    localparam int DEST_W     = 2;
    localparam int ENT_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEST_W-1:0]     dest;
        logic [ENT_DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/demux_feeder_if.sv
// Upstream word handshake plus the select/data bus towards the nibble demux.
// Pure wiring: no latency.
// Backpressure is carried by in_ready upstream and chan_ready downstream.
interface demux_feeder_if #(
    parameter int DATA_W = 4
);
    import demux_feeder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DEST_W-1:0] in_dest;
    logic              rr_mode;
    logic [NUM_CH-1:0] chan_ready;
    logic [DEST_W-1:0] out_sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              drop;
    logic              err;

    modport master (
        output in_valid, in_data, in_dest, rr_mode, chan_ready,
        input  in_ready, out_sel, out_data, out_valid, drop, err
    );

    modport slave (
        input  in_valid, in_data, in_dest, rr_mode, chan_ready,
        output in_ready, out_sel, out_data, out_valid, drop, err
    );
endinterface

// File: rtl/demux_feeder_fifo.sv
// Synchronous FIFO with registered count and fall-through (combinational) head read.
// Latency: a pushed word is visible at rd_dat the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module feeder_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
endmodule

// File: rtl/demux_feeder.sv
// Buffers (data,dest) words and presents them one at a time as a registered select/data pair.
// Latency: word pushed into an empty block appears on out_* one edge after the push edge.
// Backpressure: holds on chan_ready[out_sel]=0; DEMUX_FEEDER_TIMEOUT_EN drops after TIMEOUT stalls.
module demux_feeder #(
    parameter int DATA_W  = demux_feeder_pkg::ENT_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_feeder_if.slave  bus
);
    import demux_feeder_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_V = CNT_W'(TIMEOUT);

    state_t            state;
    state_t            nxt;
    entry_t            push_ent;
    entry_t            head;
    logic              push;
    logic              pop;
    logic              xfer;
    logic              tmo;
    logic              done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_cnt;
    logic [DEST_W-1:0] rr_ptr;
    logic [DEST_W-1:0] sel_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  stall_cnt;

    assign bus.in_ready = (fifo_cnt < (AW+1)'(DEPTH));
    assign push         = bus.in_valid && !fifo_full;

    always_comb begin
        push_ent.dest = bus.rr_mode ? rr_ptr : bus.in_dest;
        push_ent.data = bus.in_data;
    end

    feeder_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wr_dat (push_ent),
        .pop    (pop),
        .rd_dat (head),
        .count  (fifo_cnt),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign xfer = (state != IDLE) && bus.chan_ready[sel_q];

`ifdef DEMUX_FEEDER_TIMEOUT_EN
    // A late ready on the timeout cycle wins: it is a normal transfer, not a drop.
    assign tmo = (state == STALL) && (stall_cnt == TMO_V) && !xfer;
`else
    assign tmo = 1'b0;
`endif
    assign done = xfer || tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:        nxt = fifo_empty ? IDLE : SEND;
            SEND, STALL: nxt = done ? (fifo_empty ? IDLE : SEND) : STALL;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:        pop = !fifo_empty;
            SEND, STALL: pop = done && !fifo_empty;
            default:     pop = 1'b0;
        endcase
    end

    // Output register: loads on every pop, clears data when the FSM falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            data_q    <= '0;
            stall_cnt <= '0;
        end else if (pop) begin
            sel_q     <= head.dest;
            data_q    <= head.data;
            stall_cnt <= '0;
        end else if (done) begin
            data_q    <= '0;
        end else if (state != IDLE && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rr_ptr <= '0;
        else if (push && bus.rr_mode)  rr_ptr <= rr_ptr + 1'b1;
    end

    assign bus.out_valid = (state != IDLE);
    assign bus.out_sel   = sel_q;
    assign bus.out_data  = data_q;

`ifdef DEMUX_FEEDER_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   err_q <= 1'b0;
        else if (tmo) err_q <= 1'b1;
    end

    assign bus.drop = tmo;
    assign bus.err  = err_q;
`else
    assign bus.drop = 1'b0;
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_demux_feeder.sv
// Directed bench for demux_feeder; outputs sampled on the falling edge, inputs changed there too.
module tb_demux_feeder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef DEMUX_FEEDER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    demux_feeder_if #(.DATA_W(4)) bus ();

    demux_feeder #(
        .DATA_W  (4),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {valid, sel[1:0], data[3:0]}.
    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        chk(tag, {25'd0, bus.out_valid, bus.out_sel, bus.out_data}, {25'd0, v, s, d});
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] dst);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_dest  = dst;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [3:0] t1_d [4];
    int         drops;

    initial begin
        t1_d = '{4'hA, 4'h5, 4'h3, 4'hF};
        rst_n          = 1'b0;
        bus.rr_mode    = 1'b0;
        bus.chan_ready = 4'hF;
        drive(1'b0, 4'h0, 2'd0);

        // Reset state
        #2;
        chk_out("rst_out", 1'b0, 2'd0, 4'h0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_drop_err", {30'd0, bus.drop, bus.err}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_out("rst_idle", 1'b0, 2'd0, 4'h0);

        // Explicit destinations, back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t1_d[i], 2'(i));
            cyc();
            if (i > 0) chk_out("t1_word", 1'b1, 2'(i - 1), t1_d[i - 1]);
        end
        drive(1'b0, 4'h0, 2'd0);
        cyc();
        chk_out("t1_last", 1'b1, 2'd3, 4'hF);
        cyc();
        chk_out("t1_idle", 1'b0, 2'd3, 4'h0);

        // Round-robin destinations ignore in_dest
        bus.rr_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(i + 1), 2'd3);
            cyc();
            if (i > 0) chk_out("t2_rr", 1'b1, 2'(i - 1), 4'(i));
        end
        drive(1'b0, 4'h0, 2'd0);
        bus.rr_mode = 1'b0;
        cyc();
        chk_out("t2_rr_last", 1'b1, 2'd1, 4'h6);
        cyc();
        chk_out("t2_idle", 1'b0, 2'd1, 4'h0);

        // All channels blocked: fill to DEPTH queued, then drain in order
        bus.chan_ready = 4'h0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i + 8), 2'(i));
            cyc();
            chk("t3_in_ready", {31'd0, bus.in_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i > 0) chk_out("t3_hold", 1'b1, 2'd0, 4'h8);
        end
        drive(1'b0, 4'h0, 2'd0);
        bus.chan_ready = 4'hF;
        for (int j = 1; j < 5; j++) begin
            cyc();
            chk_out("t3_drain", 1'b1, 2'(j), 4'(j + 8));
            if (j == 1) chk("t3_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        end
        cyc();
        chk_out("t3_idle", 1'b0, 2'd0, 4'h0);

        // Channel 2 stalls for TIMEOUT cycles, channel 0 word queued behind it
        bus.chan_ready = 4'b1011;
        drive(1'b1, 4'h7, 2'd2);
        cyc();
        drive(1'b1, 4'h9, 2'd0);
        cyc();
        drive(1'b0, 4'h0, 2'd0);
        chk_out("t4_present", 1'b1, 2'd2, 4'h7);
        drops = 0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            drops += int'(bus.drop);
            chk("t4_drop", {31'd0, bus.drop}, (TMO_EN && j == 15) ? 32'd1 : 32'd0);
            chk_out("t4_stall_hold", 1'b1, 2'd2, 4'h7);
        end
        chk("t4_drop_count", drops, TMO_EN ? 32'd1 : 32'd0);
`ifdef DEMUX_FEEDER_TIMEOUT_EN
        cyc();
        chk("t4_drop_clear", {31'd0, bus.drop}, 32'd0);
        chk("t4_err", {31'd0, bus.err}, 32'd1);
        chk_out("t4_next", 1'b1, 2'd0, 4'h9);
        cyc();
        chk_out("t4_idle", 1'b0, 2'd0, 4'h0);
        chk("t4_err_sticky", {31'd0, bus.err}, 32'd1);
        bus.chan_ready = 4'hF;
`else
        cyc();
        chk_out("t4_wait_forever", 1'b1, 2'd2, 4'h7);
        chk("t4_err", {31'd0, bus.err}, 32'd0);
        bus.chan_ready = 4'hF;
        cyc();
        chk_out("t4_next", 1'b1, 2'd0, 4'h9);
        cyc();
        chk_out("t4_idle", 1'b0, 2'd0, 4'h0);
`endif

        // Asynchronous reset with words queued
        bus.chan_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 2'(i + 1));
            cyc();
        end
        drive(1'b0, 4'h0, 2'd0);
        chk_out("t5_pre_reset", 1'b1, 2'd1, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5_async_out", 1'b0, 2'd0, 4'h0);
        chk("t5_async_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t5_async_err", {30'd0, bus.drop, bus.err}, 32'd0);
        cyc();
        rst_n = 1'b1;
        bus.chan_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_out("t5_no_stale", 1'b0, 2'd0, 4'h0);
        end
        bus.rr_mode = 1'b1;
        drive(1'b1, 4'hC, 2'd3);
        cyc();
        drive(1'b0, 4'h0, 2'd0);
        bus.rr_mode = 1'b0;
        cyc();
        chk_out("t5_rr_ptr_reset", 1'b1, 2'd0, 4'hC);
        cyc();
        chk_out("t5_idle", 1'b0, 2'd0, 4'h0);

        // Simultaneous push and transfer holding count at 2
        bus.chan_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i), 2'(i));
            cyc();
        end
        chk("t6_count_start", {29'd0, dut.u_fifo.count}, 32'd2);
        chk_out("t6_head", 1'b1, 2'd0, 4'h0);
        bus.chan_ready = 4'hF;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 4'(k + 3), 2'(k + 3));
            cyc();
            chk_out("t6_order", 1'b1, 2'(k + 1), 4'(k + 1));
            chk("t6_count", {29'd0, dut.u_fifo.count}, 32'd2);
        end
        drive(1'b0, 4'h0, 2'd0);
        for (int k = 11; k < 13; k++) begin
            cyc();
            chk_out("t6_tail", 1'b1, 2'(k), 4'(k));
        end
        cyc();
        chk_out("t6_idle", 1'b0, 2'd0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
